// File: rtl/jtframe_rom_nslots.sv
// Multi-slot ROM read arbiter in front of an SDRAM controller; each slot keeps a one-word cache.
// Define JTFRAME_SLOTS_RR_EN for round-robin arbitration; default is fixed priority (slot 0 highest).
module jtframe_rom_nslots #(
  parameter int NS = 5,
  parameter int SDRAMW = 22,
  parameter int AW = 20,
  parameter int DW = 8,
  parameter logic [NS*SDRAMW-1:0] OFFSETS = '0
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NS*AW-1:0]     slot_addr,
  input  logic [NS-1:0]        slot_cs,
  output logic [NS*DW-1:0]     slot_dout,
  output logic [NS-1:0]        slot_ok,
  input  logic                 sdram_ack,
  output logic                 sdram_rd,
  output logic [SDRAMW-1:0]    sdram_addr,
  input  logic                 data_dst,
  input  logic                 data_rdy,
  input  logic [15:0]          data_read
);

  localparam int IW = NS > 1 ? $clog2(NS) : 1;
  localparam int XW = AW > SDRAMW ? AW : SDRAMW;

  logic [SDRAMW-1:0] ra    [NS];
  logic [SDRAMW-1:0] tag   [NS];
  logic [15:0]       cdata [NS];
  logic [NS-1:0]     valid, hit, req, eligible, gnt, sel;
  logic [IW-1:0]     gnt_idx, sel_idx;
  logic [XW-1:0]     wx;
  logic              found;
  logic              unused_dst;

  assign unused_dst = data_dst;

  // Request address per slot and cache hit detection
  always_comb begin
    wx = '0;
    for (int i = 0; i < NS; i++) begin
      wx = XW'(slot_addr[i*AW +: AW]);
      if (DW == 8) wx = wx >> 1;
      ra[i]  = OFFSETS[i*SDRAMW +: SDRAMW] + wx[SDRAMW-1:0];
      hit[i] = valid[i] && (tag[i] == ra[i]);
      req[i] = slot_cs[i] && !hit[i];
    end
  end

  // A slot whose fetch is in flight is never a candidate, even as its data arrives
  assign eligible = req & ~sel;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NS; i++)
      if (sel[i]) sel_idx = IW'(i);
  end

`ifdef JTFRAME_SLOTS_RR_EN
  logic [IW-1:0] last;
  int            cand;
  logic [IW-1:0] cidx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    cidx    = '0;
    for (int k = 1; k <= NS; k++) begin
      cand = int'(last) + k;
      if (cand >= NS) cand = cand - NS;
      cidx = IW'(cand);
      if (!found && eligible[cidx]) begin
        found        = 1'b1;
        gnt[cidx]    = 1'b1;
        gnt_idx      = cidx;
      end
    end
  end
`else
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!found && eligible[i]) begin
        found   = 1'b1;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

  // Registered state: cache fill, grant and read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel        <= '0;
      sdram_rd   <= 1'b0;
      sdram_addr <= '0;
      slot_ok    <= '0;
      valid      <= '0;
`ifdef JTFRAME_SLOTS_RR_EN
      last       <= '0;
`endif
      for (int i = 0; i < NS; i++) begin
        tag[i]   <= '0;
        cdata[i] <= '0;
      end
    end else begin
      slot_ok <= slot_cs & hit;
      // Fill uses the address registered at grant time, not the slot's current address
      if (data_rdy && |sel) begin
        valid[sel_idx] <= 1'b1;
        tag[sel_idx]   <= sdram_addr;
        cdata[sel_idx] <= data_read;
      end
      if (sel == '0 || data_rdy) begin
        sel      <= gnt;
        sdram_rd <= found;
        if (found) begin
          sdram_addr <= ra[gnt_idx];
`ifdef JTFRAME_SLOTS_RR_EN
          last       <= gnt_idx;
`endif
        end
      end else if (sdram_ack) begin
        sdram_rd <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NS; g++) begin : g_dout
    if (DW == 16) begin : g_word
      assign slot_dout[g*DW +: DW] = cdata[g];
    end else begin : g_byte
      assign slot_dout[g*DW +: DW] = slot_addr[g*AW] ? cdata[g][15:8] : cdata[g][7:0];
    end
  end

endmodule

// File: doc/jtframe_rom_nslots.md
JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 SHALL have parameter NS, default 5, number of read slots (1..8).
REQ-002 SHALL have parameter SDRAMW, default 22, SDRAM word-address width.
REQ-003 SHALL have parameter AW, default 20, slot address width; byte address when DW=8, word address when DW=16.
REQ-004 SHALL have parameter DW, default 8, slot data width; only 8 and 16 are legal, common to all slots.
REQ-005 SHALL have parameter OFFSETS, default 0, NS*SDRAMW packed per-slot SDRAM word offsets, slot i at bits [i*SDRAMW +: SDRAMW].
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port slot_addr  input  NS*AW  packed slot addresses.
REQ-009 SHALL have port slot_cs  input  NS  per-slot read request.
REQ-010 SHALL have port slot_dout  output  NS*DW  packed slot read data.
REQ-011 SHALL have port slot_ok  output  NS  per-slot data valid.
REQ-012 SHALL have port sdram_ack  input  1  controller accepted request.
REQ-013 SHALL have port sdram_rd  output  1  read request to controller.
REQ-014 SHALL have port sdram_addr  output  SDRAMW  SDRAM word address.
REQ-015 SHALL have port data_dst  input  1  data-start strobe (accepted, unused).
REQ-016 SHALL have port data_rdy  input  1  read data valid, one-cycle pulse.
REQ-017 SHALL have port data_read  input  16  SDRAM read data.

Function
REQ-018 SHALL hold per slot a one-entry cache: valid bit, SDRAMW-bit tag, 16-bit data.
REQ-019 SHALL form word address wa_i = slot_addr_i>>1 (DW=8) or slot_addr_i (DW=16), zero-extended, and request address ra_i = OFFSETS_i + wa_i modulo 2^SDRAMW.
REQ-020 SHALL define hit_i = valid_i & (tag_i == ra_i); req_i = slot_cs_i & ~hit_i.
REQ-021 SHALL register slot_ok_i <= slot_cs_i & hit_i each cycle (1-cycle hit latency); slot_ok_i is 0 in any cycle after slot_cs_i was low.
REQ-022 SHALL drive slot_dout_i from cache data: DW=16 full word; DW=8 byte [15:8] when slot_addr_i[0]=1, else [7:0].
REQ-023 SHALL keep a one-hot grant vector sel (0 = idle); eligible = req & ~sel.
REQ-024 SHALL grant when sel==0 or data_rdy=1: sel <= one eligible slot (or 0 if none), sdram_addr <= its ra, sdram_rd <= |eligible.
REQ-025 SHALL clear sdram_rd on sdram_ack unless a new grant in the same cycle sets it.
REQ-026 SHALL, on data_rdy with sel!=0, write data_read to the selected slot's cache, set tag to the sdram_addr of that grant, set valid.
REQ-027 SHALL ignore data_rdy when sel==0 (no cache change).
REQ-028 SHALL not re-grant a slot in the same cycle its own data_rdy arrives.
REQ-029 SHALL, if a slot address changes while its fetch is pending, still fill the cache with the granted tag; the slot re-requests on the next cycle if the tag mismatches.
REQ-030 SHALL never assert more than one sel bit.

Reset
REQ-031 SHALL on rst clear sel, sdram_rd, sdram_addr, slot_ok, all valid bits, tags and cache data, and the round-robin pointer to slot 0.
REQ-032 SHALL abandon any in-flight read on reset; a later data_rdy with sel==0 is dropped per REQ-027.

Configuration
REQ-033 SHALL, with JTFRAME_SLOTS_RR_EN defined, arbitrate round-robin: search eligible slots starting at (last granted index+1) mod NS, pointer updated on each grant.
REQ-034 SHALL, without JTFRAME_SLOTS_RR_EN, arbitrate by fixed priority, lowest index wins.

Verification
REQ-035 SHALL test cold miss: NS=5, DW=8, OFFSETS slot2=0x1000, slot2_addr=0x0005, cs=1 -> sdram_rd=1, sdram_addr=0x1002; data_rdy with 0xABCD -> next cycle slot2_ok=1, dout=0xAB.
REQ-036 SHALL test hit: same slot, addr 0x0004 after fill -> no sdram_rd, slot_ok=1 one cycle later, dout=0xCD.
REQ-037 SHALL test simultaneous requests slots 0,1,3 missing, without macro -> grants ordered 0,1,3; with JTFRAME_SLOTS_RR_EN after last grant 1 -> order 3,0,1.
REQ-038 SHALL test back-to-back: data_rdy for slot 0 while slot 4 pending -> same-cycle grant to slot 4, sdram_rd stays 1, slot 0 not re-granted.
REQ-039 SHALL test reset mid-read: rst pulsed after sdram_ack, then data_rdy -> no cache fill, all slot_ok=0, sdram_rd=0.
REQ-040 SHALL test address change while pending: slot1 0x10 -> 0x20 before data_rdy -> cache tag for 0x10, slot1_ok stays 0, new request for 0x20 issued.
